// File: rtl/pattern_101_serial_tx_pkg.sv
// Shared types for the 101-pattern serialiser: frame FSM states, detector
// states and the default frame width.
package pat101_pkg;

  localparam int W_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } frame_state_t;

  typedef enum logic [1:0] {
    DET_S0  = 2'd0,
    DET_S1  = 2'd1,
    DET_S10 = 2'd2
  } det_state_t;

endpackage

// File: rtl/pattern_101_serial_tx_if.sv
// Load/serial/count bundle of the 101-pattern serialiser; the block itself
// uses the slave side, a producer/consumer pair uses the master side.
interface pattern_101_serial_tx_if
  import pat101_pkg::*;
#(
  parameter int W = W_DEFAULT
);
  localparam int CW = $clog2(W);

  logic          load_valid;
  logic          load_ready;
  logic [W-1:0]  load_data;
  logic          overlap;
  logic          tx_bit;
  logic          tx_valid;
  logic          tx_ready;
  logic          tx_last;
  logic [CW-1:0] count;
  logic          count_valid;

  modport slave (
    input  load_valid, load_data, overlap, tx_ready,
    output load_ready, tx_bit, tx_valid, tx_last, count, count_valid
  );

  modport master (
    output load_valid, load_data, overlap, tx_ready,
    input  load_ready, tx_bit, tx_valid, tx_last, count, count_valid
  );

endinterface

// File: rtl/pattern_101_serial_tx_detector.sv
// Mealy 101 detector advancing only on transferred bits; clr forces S0 so
// patterns never span frames.
module seq_101_detector
  import pat101_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       bit_en,
  input  logic       bit_in,
  input  logic       overlap,
  output logic       hit,
  output det_state_t state
);

  det_state_t state_reg, state_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= DET_S0;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    hit        = 1'b0;
    if (clr) begin
      state_next = DET_S0;
    end else if (bit_en) begin
      case (state_reg)
        DET_S0:  state_next = bit_in ? DET_S1 : DET_S0;
        DET_S1:  state_next = bit_in ? DET_S1 : DET_S10;
        DET_S10: begin
          if (bit_in) begin
            hit        = 1'b1;
            // Overlap keeps the trailing 1 as the start of the next pattern
            state_next = overlap ? DET_S1 : DET_S0;
          end else begin
            state_next = DET_S0;
          end
        end
        default: state_next = DET_S0;
      endcase
    end
  end

  assign state = state_reg;

endmodule

// File: rtl/pattern_101_serial_tx.sv
// Serialises a W-bit word MSB first over valid/ready; with PAT101_COUNT_EN
// defined it also reports the number of 101 patterns in each frame.
module pattern_101_serial_tx
  import pat101_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pattern_101_serial_tx_if.slave bus
);

  localparam int CW = $clog2(W);

  frame_state_t  state_reg, state_next;
  logic [W-1:0]  shreg_reg;
  logic [CW-1:0] idx_reg;
  logic          accept;
  logic          xfer;
  logic          last;
  logic          load_ready_c, tx_valid_c, tx_bit_c, tx_last_c, done_c;

  assign last   = (idx_reg == CW'(W - 1));
  assign accept = bus.load_valid && load_ready_c;
  assign xfer   = tx_valid_c && bus.tx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next   = state_reg;
    load_ready_c = 1'b0;
    tx_valid_c   = 1'b0;
    tx_bit_c     = 1'b0;
    tx_last_c    = 1'b0;
    done_c       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        load_ready_c = 1'b1;
        if (bus.load_valid) state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        tx_valid_c = 1'b1;
        tx_bit_c   = shreg_reg[W-1];
        tx_last_c  = last;
        if (bus.tx_ready && last) state_next = ST_DONE;
      end
      ST_DONE: begin
        done_c     = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_reg <= '0;
      idx_reg   <= '0;
    end else if (accept) begin
      shreg_reg <= bus.load_data;
      idx_reg   <= '0;
    end else if (xfer) begin
      shreg_reg <= {shreg_reg[W-2:0], 1'b0};
      idx_reg   <= idx_reg + CW'(1);
    end
  end

  assign bus.load_ready = load_ready_c;
  assign bus.tx_valid   = tx_valid_c;
  assign bus.tx_bit     = tx_bit_c;
  assign bus.tx_last    = tx_last_c;

`ifdef PAT101_COUNT_EN
  logic          mode_reg;
  logic [CW-1:0] count_reg;
  logic          hit;
  det_state_t    unused_det_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_reg  <= 1'b0;
      count_reg <= '0;
    end else if (accept) begin
      mode_reg  <= bus.overlap;
      count_reg <= '0;
    end else if (hit) begin
      // Cannot wrap: at most W-2 patterns fit in a frame
      count_reg <= count_reg + CW'(1);
    end
  end

  seq_101_detector u_det (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (accept),
    .bit_en  (xfer),
    .bit_in  (tx_bit_c),
    .overlap (mode_reg),
    .hit     (hit),
    .state   (unused_det_state)
  );

  assign bus.count       = count_reg;
  assign bus.count_valid = done_c;
`else
  logic unused_count_inputs;
  assign unused_count_inputs = bus.overlap ^ done_c;
  assign bus.count           = '0;
  assign bus.count_valid     = 1'b0;
`endif

endmodule
